alu_decoder: RTL and testbench
==============================

# alu_decoder

Decodes RV32I instruction fields (opcode, func3, func7) into the 4-bit ALU operation select consumed by the ALU in the single-cycle datapath. It sits inside the main controller, beside the datapath-control decode. The ALU select and the illegal-instruction flag are purely combinational, so they are valid in the same cycle as the instruction. A small clocked block records the first illegal encoding for debug.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- opcode  input  7  instruction bits [6:0].
- func3  input  3  instruction bits [14:12].
- func7  input  7  instruction bits [31:25].
- instr_valid  input  1  qualifies the fields for error capture.
- clear_err  input  1  synchronous clear of the error capture.
- alu_control  output  4  ALU operation select; combinational.
- illegal  output  1  current fields are not a supported RV32I encoding; combinational.
- err_sticky  output  1  registered; set on the first illegal instruction.
- err_opcode  output  7  registered; opcode of the first illegal instruction.

## Operation
ALU encoding is {sub/arith bit, func3}:
- ADD = 0000, SUB = 1000
- SLL = 0001, SLT = 0010, SLTU = 0011
- XOR = 0100, SRL = 0101, SRA = 1101
- OR = 0110, AND = 0111
- PASS_B = 1001 (result = operand 2)
- All other codes are unused and never driven.

Decode per opcode:
- OP (0110011):
  - func7 = 0000000 → {0, func3}.
  - func7 = 0100000 with func3 = 000 → SUB; with func3 = 101 → SRA.
  - Any other func7/func3 combination is illegal.
- OP-IMM (0010011):
  - func3 ∈ {000, 010, 011, 100, 110, 111} → {0, func3}; func7 is ignored because it carries immediate bits.
  - func3 = 001 requires func7 = 0000000 → SLL.
  - func3 = 101: func7 = 0000000 → SRL; func7 = 0100000 → SRA.
  - Any other shift func7 is illegal.
- LOAD (0000011): ADD. func3 must be one of 000, 001, 010, 100, 101; otherwise illegal.
- STORE (0100011): ADD. func3 must be 000, 001 or 010; otherwise illegal.
- BRANCH (1100011), used for the comparison; the branch unit interprets the result:
  - func3 000 (BEQ) and 001 (BNE) → SUB.
  - func3 100 (BLT) and 101 (BGE) → SLT.
  - func3 110 (BLTU) and 111 (BGEU) → SLTU.
  - func3 010 and 011 are illegal.
- LUI (0110111): PASS_B.
- AUIPC (0010111), JAL (1101111): ADD.
- JALR (1100111): ADD. func3 must be 000; otherwise illegal.
- Any other opcode is illegal.

Illegal handling:
- Whenever illegal = 1, alu_control = ADD (0000). The output is never X or undefined.
- illegal = 0 for every legal encoding listed above.

Error capture (clocked):
- On a rising edge with instr_valid = 1, illegal = 1 and err_sticky = 0: set err_sticky = 1 and err_opcode = opcode.
- Later illegal instructions do not overwrite err_opcode while err_sticky = 1.
- clear_err = 1 on a rising edge clears err_sticky to 0 and err_opcode to 0. It takes priority over a capture in the same cycle.
- instr_valid = 0 blocks capture; the combinational outputs are unaffected.

## Timing
- alu_control and illegal are purely combinational: zero-cycle latency from the inputs, with no dependence on clk or rst_n.
- err_sticky and err_opcode update on the rising edge of clk and are visible one cycle after the qualifying edge.
- Reset values: err_sticky = 0, err_opcode = 0000000.
- Asserting rst_n low clears the registers immediately, independent of clk. Reset in the middle of a capture cycle wins.
- There is no handshake; instr_valid is a level qualifier sampled at each edge.

## Test plan
- OP sweep: opcode 0110011 with func7 = 0100000, func3 = 000 → alu_control = 1000. With func3 = 101 → 1101. With func7 = 0, func3 = 111 → 0111. illegal = 0 in all three cases.
- OP-IMM: ADDI (func3 000) with func7 = 1111111 → 0000, illegal = 0. SRAI (func7 0100000, func3 101) → 1101. SLLI with func7 = 0100000 → illegal = 1, alu_control = 0000.
- BRANCH: func3 000 → 1000, 110 → 0011, 101 → 0010, 010 → illegal = 1. LUI → 1001. JALR with func3 = 001 → illegal = 1.
- Error capture: after reset, opcode 1111111 with instr_valid = 1 for one edge → err_sticky = 1, err_opcode = 1111111. A following illegal opcode 0000000 leaves err_opcode = 1111111.
- Clear and qualification: clear_err = 1 for one edge → err_sticky = 0, err_opcode = 0. An illegal opcode with instr_valid = 0 → err_sticky stays 0.
- Async reset: with err_sticky = 1, pulse rst_n low between clock edges → both registers are 0 immediately. Combinational outputs continue to track the inputs during reset.

Source files
------------

// File: rtl/alu_decoder.sv
// alu_decoder: RV32I opcode/func3/func7 to 4-bit ALU select decoder.
// ALU select and illegal flag are combinational; a small clocked block
// latches the opcode of the first qualified illegal instruction for debug.
module alu_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       instr_valid,
  input  logic       clear_err,
  output logic [3:0] alu_control,
  output logic       illegal,
  output logic       err_sticky,
  output logic [6:0] err_opcode
);

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU select codes: {sub/arith bit, func3}
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;

  logic [3:0] alu_sel;
  logic       ill;
  logic       err_sticky_q, err_sticky_d;
  logic [6:0] err_opcode_q, err_opcode_d;

  // Decode the instruction fields; illegal encodings force ADD so the
  // output is always a defined code.
  always_comb begin
    alu_sel = ALU_ADD;
    ill     = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (func7 == F7_BASE)                        alu_sel = {1'b0, func3};
        else if (func7 == F7_ALT && func3 == 3'b000) alu_sel = ALU_SUB;
        else if (func7 == F7_ALT && func3 == 3'b101) alu_sel = ALU_SRA;
        else                                         ill     = 1'b1;
      end
      OPC_OP_IMM: begin
        case (func3)
          3'b001: begin
            if (func7 == F7_BASE) alu_sel = ALU_SLL;
            else                  ill     = 1'b1;
          end
          3'b101: begin
            if (func7 == F7_BASE)     alu_sel = ALU_SRL;
            else if (func7 == F7_ALT) alu_sel = ALU_SRA;
            else                      ill     = 1'b1;
          end
          // func7 holds immediate bits for the non-shift forms
          default: alu_sel = {1'b0, func3};
        endcase
      end
      OPC_LOAD: begin
        case (func3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: alu_sel = ALU_ADD;
          default:                                ill     = 1'b1;
        endcase
      end
      OPC_STORE: begin
        case (func3)
          3'b000, 3'b001, 3'b010: alu_sel = ALU_ADD;
          default:                ill     = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        case (func3)
          3'b000, 3'b001: alu_sel = ALU_SUB;
          3'b100, 3'b101: alu_sel = ALU_SLT;
          3'b110, 3'b111: alu_sel = ALU_SLTU;
          default:        ill     = 1'b1;
        endcase
      end
      OPC_LUI:             alu_sel = ALU_PASS_B;
      OPC_AUIPC, OPC_JAL:  alu_sel = ALU_ADD;
      OPC_JALR: begin
        if (func3 == 3'b000) alu_sel = ALU_ADD;
        else                 ill     = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) alu_sel = ALU_ADD;
  end

  // Next state of the error capture; clear beats a same-cycle capture.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_opcode_d = err_opcode_q;
    if (clear_err) begin
      err_sticky_d = 1'b0;
      err_opcode_d = 7'b0000000;
    end else if (instr_valid && ill && !err_sticky_q) begin
      err_sticky_d = 1'b1;
      err_opcode_d = opcode;
    end
  end

  // Error capture registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
      err_opcode_q <= 7'b0000000;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_opcode_q <= err_opcode_d;
    end
  end

  assign alu_control = alu_sel;
  assign illegal     = ill;
  assign err_sticky  = err_sticky_q;
  assign err_opcode  = err_opcode_q;

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: directed vectors with a scoreboard queue. Stimulus pushes
// hand-computed expectations; a monitor pops and compares them at each
// falling edge, or immediately when the stimulus raises sample_ev.
module tb_alu_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       instr_valid;
  logic       clear_err;
  logic [3:0] alu_control;
  logic       illegal;
  logic       err_sticky;
  logic [6:0] err_opcode;

  typedef struct {
    string      name;
    bit         is_err;
    logic [3:0] alu;
    logic       ill;
    logic       st;
    logic [6:0] eo;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  event sample_ev;

  alu_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .func3       (func3),
    .func7       (func7),
    .instr_valid (instr_valid),
    .clear_err   (clear_err),
    .alu_control (alu_control),
    .illegal     (illegal),
    .err_sticky  (err_sticky),
    .err_opcode  (err_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation against the DUT outputs.
  initial begin
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk or sample_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (e.is_err) begin
          if (err_sticky !== e.st || err_opcode !== e.eo) begin
            errors++;
            $display("FAIL %s: err_sticky=%b err_opcode=%b, expected %b %b",
                     e.name, err_sticky, err_opcode, e.st, e.eo);
          end
        end else begin
          if (alu_control !== e.alu || illegal !== e.ill) begin
            errors++;
            $display("FAIL %s: alu_control=%b illegal=%b, expected %b %b",
                     e.name, alu_control, illegal, e.alu, e.ill);
          end
        end
      end
    end
  end

  // Drive one instruction just after a rising edge and queue its decode.
  task automatic apply(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic v, input logic c,
                       input logic [3:0] ea, input logic ei, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    opcode      = op;
    func3       = f3;
    func7       = f7;
    instr_valid = v;
    clear_err   = c;
    e.name = nm; e.is_err = 1'b0; e.alu = ea; e.ill = ei; e.st = 1'b0; e.eo = '0;
    sb_q.push_back(e);
  endtask

  // Queue an expectation for the error capture registers.
  task automatic expect_err(input logic st, input logic [6:0] eo, input string nm);
    exp_t e;
    e.name = nm; e.is_err = 1'b1; e.alu = '0; e.ill = 1'b0; e.st = st; e.eo = eo;
    sb_q.push_back(e);
  endtask

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] F7A = 7'b0100000;
  localparam logic [6:0] Z7  = 7'b0000000;

  initial begin
    rst_n = 1'b0; opcode = OP; func3 = 3'b000; func7 = Z7;
    instr_valid = 1'b0; clear_err = 1'b0;
    #3;
    expect_err(1'b0, Z7, "reset_state");
    -> sample_ev;
    #10 rst_n = 1'b1;

    // Combinational decode, not qualified
    apply(OP, 3'b000, F7A, 0, 0, 4'b1000, 0, "op_sub");
    apply(OP, 3'b101, F7A, 0, 0, 4'b1101, 0, "op_sra");
    apply(OP, 3'b111, Z7, 0, 0, 4'b0111, 0, "op_and");
    apply(OP, 3'b001, F7A, 0, 0, 4'b0000, 1, "op_bad_f7");
    apply(IMM, 3'b000, 7'h7F, 0, 0, 4'b0000, 0, "addi_imm_bits");
    apply(IMM, 3'b101, F7A, 0, 0, 4'b1101, 0, "srai");
    apply(IMM, 3'b001, F7A, 0, 0, 4'b0000, 1, "slli_bad_f7");
    apply(IMM, 3'b011, 7'h55, 0, 0, 4'b0011, 0, "sltiu");
    apply(BR, 3'b000, Z7, 0, 0, 4'b1000, 0, "beq");
    apply(BR, 3'b110, Z7, 0, 0, 4'b0011, 0, "bltu");
    apply(BR, 3'b101, Z7, 0, 0, 4'b0010, 0, "bge");
    apply(BR, 3'b010, Z7, 0, 0, 4'b0000, 1, "br_f3_010");
    apply(7'b0110111, 3'b000, Z7, 0, 0, 4'b1001, 0, "lui");
    apply(7'b1100111, 3'b001, Z7, 0, 0, 4'b0000, 1, "jalr_bad_f3");
    apply(7'b1100111, 3'b000, Z7, 0, 0, 4'b0000, 0, "jalr");
    apply(7'b0000011, 3'b011, Z7, 0, 0, 4'b0000, 1, "load_bad_f3");
    apply(7'b0000011, 3'b100, Z7, 0, 0, 4'b0000, 0, "lbu");
    apply(7'b0100011, 3'b011, Z7, 0, 0, 4'b0000, 1, "store_bad_f3");
    apply(7'b0100011, 3'b010, Z7, 0, 0, 4'b0000, 0, "sw");
    apply(7'b0010111, 3'b111, 7'h7F, 0, 0, 4'b0000, 0, "auipc");
    apply(7'b1101111, 3'b000, Z7, 0, 0, 4'b0000, 0, "jal");
    apply(7'b1111111, 3'b000, Z7, 0, 0, 4'b0000, 1, "bad_opcode_unqual");
    apply(OP, 3'b000, Z7, 0, 0, 4'b0000, 0, "add");
    expect_err(1'b0, Z7, "no_capture_unqualified");

    // First illegal captured, later one ignored
    apply(7'b1111111, 3'b000, Z7, 1, 0, 4'b0000, 1, "capture_ff");
    apply(Z7, 3'b000, Z7, 1, 0, 4'b0000, 1, "second_illegal");
    expect_err(1'b1, 7'b1111111, "captured_ff");
    apply(OP, 3'b000, Z7, 0, 0, 4'b0000, 0, "add_after_cap");
    expect_err(1'b1, 7'b1111111, "sticky_holds_ff");

    // Clear, and clear beating a same-cycle capture
    apply(OP, 3'b000, Z7, 0, 1, 4'b0000, 0, "clear");
    apply(7'b1111111, 3'b000, Z7, 1, 1, 4'b0000, 1, "clear_vs_capture");
    expect_err(1'b0, Z7, "cleared");
    apply(7'b1111111, 3'b000, Z7, 0, 0, 4'b0000, 1, "illegal_unqual");
    expect_err(1'b0, Z7, "clear_priority");
    apply(IMM, 3'b001, F7A, 1, 0, 4'b0000, 1, "slli_capture");
    expect_err(1'b0, Z7, "unqual_blocked");
    apply(OP, 3'b000, Z7, 0, 0, 4'b0000, 0, "add_after_slli");
    expect_err(1'b1, IMM, "captured_opimm");

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    expect_err(1'b0, Z7, "async_reset");
    begin
      exp_t e;
      e.name = "comb_in_reset"; e.is_err = 1'b0; e.alu = 4'b0000; e.ill = 1'b0;
      e.st = 1'b0; e.eo = '0;
      sb_q.push_back(e);
    end
    -> sample_ev;
    apply(7'b1111111, 3'b000, Z7, 1, 0, 4'b0000, 1, "illegal_in_reset");
    apply(7'b0110111, 3'b000, Z7, 0, 0, 4'b1001, 0, "lui_in_reset");
    expect_err(1'b0, Z7, "reset_blocks_capture");
    #3 rst_n = 1'b1;
    apply(OP, 3'b000, F7A, 0, 0, 4'b1000, 0, "sub_after_reset");
    expect_err(1'b0, Z7, "after_reset");

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
